// File: rtl/ciphertext_serializer_pkg.sv
// Shared paillier constants: block geometry for the ciphertext datapath and
// the per-operand block counts used by the top level.
package ciphertext_serializer_pkg;

  localparam int REGISTER_SIZE         = 32;
  localparam int NUM_BLOCKS            = 128;
  localparam int NUM_CIPHERTEXT_BLOCKS = NUM_BLOCKS;
  localparam int NUM_MODULUS_BLOCKS    = 64;
  localparam int NUM_PLAINTEXT_BLOCKS  = 64;

  // Counter width that stays legal when the count is 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ciphertext_serializer_block_buffer.sv
// Frame storage: simple dual-port RAM with one registered read port.
module block_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk_in,
  input  logic              we_in,
  input  logic [ADDR_W-1:0] waddr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [ADDR_W-1:0] raddr_in,
  output logic [DATA_W-1:0] rdata_out
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_in) begin
    if (we_in) mem_q[waddr_in] <= wdata_in;
    rdata_q <= mem_q[raddr_in];
  end

  assign rdata_out = rdata_q;

endmodule

// File: rtl/ciphertext_serializer.sv
// Collects a frame of ciphertext blocks, then streams it LSB-byte-first to a
// UART transmitter, one byte every other cycle at most.
module ciphertext_serializer #(
  parameter int REGISTER_SIZE = ciphertext_serializer_pkg::REGISTER_SIZE,
  parameter int NUM_BLOCKS    = ciphertext_serializer_pkg::NUM_BLOCKS
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     valid_in,
  input  logic [REGISTER_SIZE-1:0] block_in,
  output logic                     ready_out,
  output logic                     overflow_out,
  input  logic                     tx_busy_in,
  output logic [7:0]               byte_out,
  output logic                     byte_valid_out,
  output logic                     frame_done_out
);
  import ciphertext_serializer_pkg::*;

  localparam int BPB = REGISTER_SIZE / 8;
  localparam int AW  = clog2_min1(NUM_BLOCKS);
  localparam int SW  = clog2_min1(BPB);
  localparam logic [AW-1:0] LAST_BLK = AW'(NUM_BLOCKS - 1);
  localparam logic [SW-1:0] LAST_SUB = SW'(BPB - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      wr_cnt_q, rd_blk_q;
  logic [SW-1:0]      sub_q;
  logic               rd_vld_q;
  logic [7:0]         byte_q;
  logic               byte_vld_q, ovf_q, done_q;
  logic [REGISTER_SIZE-1:0] rd_data;
  logic               ready, accept, issue, last_in, last_byte;

  block_buffer #(
    .DATA_W(REGISTER_SIZE),
    .DEPTH (NUM_BLOCKS),
    .ADDR_W(AW)
  ) u_buf (
    .clk_in   (clk_in),
    .we_in    (accept),
    .waddr_in (wr_cnt_q),
    .wdata_in (block_in),
    .raddr_in (rd_blk_q),
    .rdata_out(rd_data)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = last_in ? SEND : COLLECT;
      COLLECT: if (accept && last_in) state_d = SEND;
      SEND:    if (issue && last_byte) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // rd_vld_q holds off the first issue until the read of block 0 has landed.
  always_comb begin
    ready     = (state_q != SEND);
    accept    = valid_in && ready;
    last_in   = (wr_cnt_q == LAST_BLK);
    last_byte = (rd_blk_q == LAST_BLK) && (sub_q == LAST_SUB);
    issue     = (state_q == SEND) && !tx_busy_in && !byte_vld_q && rd_vld_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_cnt_q   <= '0;
      rd_blk_q   <= '0;
      sub_q      <= '0;
      rd_vld_q   <= 1'b0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_vld_q   <= (state_q == SEND);
      byte_vld_q <= issue;
      done_q     <= issue && last_byte;
      ovf_q      <= valid_in && !ready;
      if (accept) wr_cnt_q <= last_in ? '0 : wr_cnt_q + AW'(1);
      // Advancing the block address right after a block's top byte gives the
      // RAM a full cycle to fetch the next block before the next issue slot.
      if (issue) begin
        byte_q <= rd_data[{sub_q, 3'b000} +: 8];
        if (sub_q == LAST_SUB) begin
          sub_q    <= '0;
          rd_blk_q <= (rd_blk_q == LAST_BLK) ? '0 : rd_blk_q + AW'(1);
        end else begin
          sub_q <= sub_q + SW'(1);
        end
      end
    end
  end

  assign ready_out      = ready;
  assign overflow_out   = ovf_q;
  assign byte_out       = byte_q;
  assign byte_valid_out = byte_vld_q;
  assign frame_done_out = done_q;

endmodule

// File: tb/tb_ciphertext_serializer.sv
// Directed bench for ciphertext_serializer at default geometry (32-bit x 128).
module tb_ciphertext_serializer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic [31:0] block_in;
  logic        ready_out, overflow_out, tx_busy_in;
  logic [7:0]  byte_out;
  logic        byte_valid_out, frame_done_out;

  always #5 clk_in = ~clk_in;

  ciphertext_serializer dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .valid_in      (valid_in),
    .block_in      (block_in),
    .ready_out     (ready_out),
    .overflow_out  (overflow_out),
    .tx_busy_in    (tx_busy_in),
    .byte_out      (byte_out),
    .byte_valid_out(byte_valid_out),
    .frame_done_out(frame_done_out)
  );

  int checks = 0, failures = 0;
  int cyc = 0;
  logic busy_at_edge = 1'b0;
  bit   busy_mode = 1'b0;
  int   busy_left = 0;

  logic [7:0] bq[$];
  int   tq[$];
  int   ovf_cnt = 0, fd_cnt = 0, fd_at = 0, busy_viol = 0;

  always @(posedge clk_in) begin
    cyc          <= cyc + 1;
    busy_at_edge <= tx_busy_in;
  end

  // Observe outputs mid-cycle; a byte's timestamp is the edge that produced it.
  always @(negedge clk_in) begin
    if (byte_valid_out === 1'b1) begin
      bq.push_back(byte_out);
      tq.push_back(cyc);
      if (busy_at_edge === 1'b1) busy_viol++;
    end
    if (overflow_out === 1'b1) ovf_cnt++;
    if (frame_done_out === 1'b1) begin
      fd_cnt++;
      fd_at = bq.size();
    end
  end

  // Transmitter model: busy for 20 cycles after each accepted byte.
  always @(negedge clk_in) begin
    if (!busy_mode) begin
      busy_left  = 0;
      tx_busy_in = 1'b0;
    end else begin
      if (byte_valid_out === 1'b1) busy_left = 20;
      else if (busy_left > 0) busy_left--;
      tx_busy_in = (busy_left != 0);
    end
  end

  function automatic logic [31:0] pat_word(input int pat, input int i);
    case (pat)
      0:       return 32'h0403_0201 + i * 32'h0404_0404;
      1:       return 32'hDEAD_BEEF;
      default: return 32'hC0DE_0000 + i * 32'h0001_0103;
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(input int pat, input int j);
    logic [31:0] w;
    w = pat_word(pat, j / 4);
    return w[(j % 4) * 8 +: 8];
  endfunction

  task automatic send_blocks(input int pat, input int n, input bit now, output int last_acc);
    for (int i = 0; i < n; i++) begin
      if (i > 0 || !now) @(negedge clk_in);
      valid_in = 1'b1;
      block_in = pat_word(pat, i);
      last_acc = cyc + 1;
    end
    @(negedge clk_in);
    valid_in = 1'b0;
    block_in = '0;
  endtask

  task automatic wait_bytes(input int target, input int budget);
    for (int k = 0; k < budget && bq.size() < target; k++) @(negedge clk_in);
    repeat (30) @(negedge clk_in);
  endtask

  task automatic test_reset;
    rst_in = 1'b1; valid_in = 1'b0; block_in = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_out); end
    checks++; if (byte_valid_out !== 1'b0) begin failures++; $display("FAIL reset_byte_valid got=%b exp=0", byte_valid_out); end
    checks++; if (overflow_out !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow_out); end
    checks++; if (frame_done_out !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done_out); end
    checks++; if (byte_out !== 8'h00) begin failures++; $display("FAIL reset_byte_out got=%h exp=00", byte_out); end
  endtask

  task automatic test_stream;
    int s, sf, so, la, bad, gap;
    s = bq.size(); sf = fd_cnt; so = ovf_cnt;
    send_blocks(0, 128, 1'b0, la);
    wait_bytes(s + 512, 3000);
    checks++; if (bq.size() - s !== 512) begin failures++; $display("FAIL stream_count got=%0d exp=512", bq.size() - s); end
    bad = 0;
    for (int j = 0; j < 512 && s + j < bq.size(); j++)
      if (bq[s + j] !== exp_byte(0, j)) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL stream_bytes wrong=%0d exp=0", bad); end
    if (bq.size() > s) begin
      checks++; if (tq[s] !== la + 2) begin failures++; $display("FAIL stream_first_latency got=%0d exp=%0d", tq[s] - la, 2); end
    end
    gap = 0;
    for (int j = s + 1; j < bq.size(); j++) if (tq[j] - tq[j - 1] !== 2) gap++;
    checks++; if (gap !== 0) begin failures++; $display("FAIL stream_spacing bad_gaps=%0d exp=0", gap); end
    checks++; if (fd_cnt - sf !== 1) begin failures++; $display("FAIL stream_frame_done got=%0d exp=1", fd_cnt - sf); end
    checks++; if (fd_at !== s + 512) begin failures++; $display("FAIL stream_frame_done_pos got=%0d exp=%0d", fd_at - s, 512); end
    checks++; if (ovf_cnt - so !== 0) begin failures++; $display("FAIL stream_overflow got=%0d exp=0", ovf_cnt - so); end
  endtask

  task automatic test_busy;
    int s, sf, sv, la, bad;
    s = bq.size(); sf = fd_cnt; sv = busy_viol;
    busy_mode = 1'b1;
    send_blocks(0, 128, 1'b0, la);
    wait_bytes(s + 512, 14000);
    busy_mode = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++; if (bq.size() - s !== 512) begin failures++; $display("FAIL busy_count got=%0d exp=512", bq.size() - s); end
    bad = 0;
    for (int j = 0; j < 512 && s + j < bq.size(); j++)
      if (bq[s + j] !== exp_byte(0, j)) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL busy_bytes wrong=%0d exp=0", bad); end
    checks++; if (busy_viol - sv !== 0) begin failures++; $display("FAIL busy_issue_while_busy got=%0d exp=0", busy_viol - sv); end
    checks++; if (fd_cnt - sf !== 1) begin failures++; $display("FAIL busy_frame_done got=%0d exp=1", fd_cnt - sf); end
  endtask

  task automatic test_overflow_in_send;
    int s, so, la, bad;
    s = bq.size(); so = ovf_cnt;
    send_blocks(0, 128, 1'b0, la);
    for (int p = 0; p < 3; p++) begin
      repeat (9) @(negedge clk_in);
      checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL send_ready got=%b exp=0", ready_out); end
      valid_in = 1'b1; block_in = 32'hFFFF_FFFF;
      @(negedge clk_in);
      valid_in = 1'b0; block_in = '0;
    end
    wait_bytes(s + 512, 3000);
    checks++; if (ovf_cnt - so !== 3) begin failures++; $display("FAIL send_overflow_pulses got=%0d exp=3", ovf_cnt - so); end
    checks++; if (bq.size() - s !== 512) begin failures++; $display("FAIL send_ovf_count got=%0d exp=512", bq.size() - s); end
    bad = 0;
    for (int j = 0; j < 512 && s + j < bq.size(); j++)
      if (bq[s + j] !== exp_byte(0, j)) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL send_ovf_bytes wrong=%0d exp=0", bad); end
  endtask

  task automatic test_reset_mid;
    int s, s2, la, bad;
    s = bq.size();
    send_blocks(0, 50, 1'b0, la);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    checks++; if (ready_out !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", ready_out); end
    send_blocks(1, 128, 1'b0, la);
    wait_bytes(s + 512, 3000);
    checks++; if (bq.size() - s !== 512) begin failures++; $display("FAIL midreset_count got=%0d exp=512", bq.size() - s); end
    bad = 0;
    for (int j = 0; j < 512 && s + j < bq.size(); j++)
      if (bq[s + j] !== exp_byte(1, j)) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL midreset_bytes wrong=%0d exp=0", bad); end
    // Abort a frame partway through sending.
    s = bq.size();
    send_blocks(0, 128, 1'b0, la);
    for (int k = 0; k < 500 && bq.size() < s + 20; k++) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    s2 = bq.size();
    repeat (200) @(negedge clk_in);
    checks++; if (bq.size() !== s2) begin failures++; $display("FAIL sendreset_bytes_after got=%0d exp=0", bq.size() - s2); end
  endtask

  task automatic test_back_to_back;
    int s, so, sf, la, bad, k;
    s = bq.size(); so = ovf_cnt; sf = fd_cnt;
    send_blocks(0, 128, 1'b0, la);
    for (k = 0; k < 3000; k++) begin
      @(negedge clk_in);
      if (frame_done_out === 1'b1) break;
    end
    checks++; if (k >= 3000) begin failures++; $display("FAIL b2b_frame_done_timeout got=timeout exp=pulse"); end
    send_blocks(2, 128, 1'b1, la);
    wait_bytes(s + 1024, 3000);
    checks++; if (bq.size() - s !== 1024) begin failures++; $display("FAIL b2b_count got=%0d exp=1024", bq.size() - s); end
    bad = 0;
    for (int j = 0; j < 1024 && s + j < bq.size(); j++)
      if (bq[s + j] !== ((j < 512) ? exp_byte(0, j) : exp_byte(2, j - 512))) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_bytes wrong=%0d exp=0", bad); end
    checks++; if (ovf_cnt - so !== 0) begin failures++; $display("FAIL b2b_overflow got=%0d exp=0", ovf_cnt - so); end
    checks++; if (fd_cnt - sf !== 2) begin failures++; $display("FAIL b2b_frame_done got=%0d exp=2", fd_cnt - sf); end
  endtask

  task automatic test_final_byte_overflow;
    int s, so, la, bad, n, k;
    s = bq.size(); so = ovf_cnt;
    send_blocks(0, 128, 1'b0, la);
    n = 0;
    for (k = 0; k < 3000 && n < 511; k++) begin
      @(negedge clk_in);
      if (byte_valid_out === 1'b1) n++;
    end
    checks++; if (n !== 511) begin failures++; $display("FAIL final_wait got=%0d exp=511", n); end
    @(negedge clk_in);
    checks++; if (ready_out !== 1'b0) begin failures++; $display("FAIL final_issue_ready got=%b exp=0", ready_out); end
    valid_in = 1'b1; block_in = 32'h1234_5678;
    @(negedge clk_in);
    send_blocks(2, 128, 1'b1, la);
    wait_bytes(s + 1024, 3000);
    checks++; if (ovf_cnt - so !== 1) begin failures++; $display("FAIL final_overflow got=%0d exp=1", ovf_cnt - so); end
    checks++; if (bq.size() - s !== 1024) begin failures++; $display("FAIL final_count got=%0d exp=1024", bq.size() - s); end
    bad = 0;
    for (int j = 0; j < 1024 && s + j < bq.size(); j++)
      if (bq[s + j] !== ((j < 512) ? exp_byte(0, j) : exp_byte(2, j - 512))) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL final_bytes wrong=%0d exp=0", bad); end
  endtask

  initial begin
    rst_in = 1'b1; valid_in = 1'b0; block_in = '0;
    test_reset;
    test_stream;
    test_busy;
    test_overflow_in_send;
    test_reset_mid;
    test_back_to_back;
    test_final_byte_overflow;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
